// File: rtl/alu_rs_if.sv
`default_nettype none
// ============================================================================
//  Module : rv32i_types / alu_rs_if
//  Brief  : ALU opcode enumeration and the dispatch/CDB/issue bundle of the
//           ALU reservation station.
//  Rev    : 1.0  initial release
// ============================================================================

package rv32i_types;
    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;
endpackage

interface alu_rs_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) ();
    import rv32i_types::*;

    logic                         flush;
    logic                         dispatch_valid;
    logic                         dispatch_ready;
    alu_ops                       dispatch_aluop;
    logic [31:0]                  dispatch_src1_val;
    logic [TAG_W-1:0]             dispatch_src1_tag;
    logic                         dispatch_src1_rdy;
    logic [31:0]                  dispatch_src2_val;
    logic [TAG_W-1:0]             dispatch_src2_tag;
    logic                         dispatch_src2_rdy;
    logic [TAG_W-1:0]             dispatch_dest_tag;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [31:0]                  cdb_data;
    logic                         issue_valid;
    logic                         issue_ready;
    alu_ops                       issue_aluop;
    logic [31:0]                  issue_a;
    logic [31:0]                  issue_b;
    logic [TAG_W-1:0]             issue_dest_tag;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Station side
    modport slave (
        input  flush,
        input  dispatch_valid, dispatch_aluop,
        input  dispatch_src1_val, dispatch_src1_tag, dispatch_src1_rdy,
        input  dispatch_src2_val, dispatch_src2_tag, dispatch_src2_rdy,
        input  dispatch_dest_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        input  issue_ready,
        output dispatch_ready,
        output issue_valid, issue_aluop, issue_a, issue_b, issue_dest_tag,
        output count
    );

    // Dispatcher / CDB / ALU side
    modport master (
        output flush,
        output dispatch_valid, dispatch_aluop,
        output dispatch_src1_val, dispatch_src1_tag, dispatch_src1_rdy,
        output dispatch_src2_val, dispatch_src2_tag, dispatch_src2_rdy,
        output dispatch_dest_tag,
        output cdb_valid, cdb_tag, cdb_data,
        output issue_ready,
        input  dispatch_ready,
        input  issue_valid, issue_aluop, issue_a, issue_b, issue_dest_tag,
        input  count
    );
endinterface

`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
//  Module : alu_rs
//  Brief  : Compacting-queue reservation station for the integer ALU; snoops
//           the CDB for pending operands and issues the oldest ready op.
//  Rev    : 1.0  initial release
// ============================================================================

module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_rs_if.slave   rs
);
    import rv32i_types::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        alu_ops           op;
        logic [31:0]      v1;
        logic [TAG_W-1:0] t1;
        logic             r1;
        logic [31:0]      v2;
        logic [TAG_W-1:0] t2;
        logic             r2;
        logic [TAG_W-1:0] dest;
    } entry_t;

    entry_t          r_ent  [DEPTH];
    logic [CW-1:0]   r_count;

    entry_t          w_wake [DEPTH+1];
    entry_t          w_next [DEPTH];
    entry_t          w_din;
    logic [DEPTH-1:0] w_elig;
    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic            w_issue_fire;
    logic            w_disp_fire;
    logic [CW-1:0]   w_slot;
    logic [CW-1:0]   w_cnt_nxt;

    // Entries below count are valid; the queue is always compacted at index 0.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_elig
            assign w_elig[g] = (r_count > CW'(g)) && r_ent[g].r1 && r_ent[g].r2;
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && w_elig[i]) begin
                w_found = 1'b1;
                w_sel   = IW'(i);
            end
        end
    end

    assign rs.dispatch_ready = (r_count < CW'(DEPTH));
    assign w_issue_fire      = w_found && rs.issue_ready;
    assign w_disp_fire       = rs.dispatch_valid && rs.dispatch_ready && !rs.flush;
    assign w_slot            = r_count - CW'(w_issue_fire);
    assign w_cnt_nxt         = r_count + CW'(w_disp_fire) - CW'(w_issue_fire);

    // CDB wakeup on stored entries; slot DEPTH is the empty filler shifted in at the top.
    always_comb begin
        w_wake[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake[i] = r_ent[i];
            if (rs.cdb_valid && !r_ent[i].r1 && (r_ent[i].t1 == rs.cdb_tag)) begin
                w_wake[i].r1 = 1'b1;
                w_wake[i].v1 = rs.cdb_data;
            end
            if (rs.cdb_valid && !r_ent[i].r2 && (r_ent[i].t2 == rs.cdb_tag)) begin
                w_wake[i].r2 = 1'b1;
                w_wake[i].v2 = rs.cdb_data;
            end
        end
    end

    always_comb begin
        w_din      = '0;
        w_din.op   = rs.dispatch_aluop;
        w_din.v1   = rs.dispatch_src1_val;
        w_din.t1   = rs.dispatch_src1_tag;
        w_din.r1   = rs.dispatch_src1_rdy;
        w_din.v2   = rs.dispatch_src2_val;
        w_din.t2   = rs.dispatch_src2_tag;
        w_din.r2   = rs.dispatch_src2_rdy;
        w_din.dest = rs.dispatch_dest_tag;
        if (rs.cdb_valid && !rs.dispatch_src1_rdy && (rs.dispatch_src1_tag == rs.cdb_tag)) begin
            w_din.r1 = 1'b1;
            w_din.v1 = rs.cdb_data;
        end
        if (rs.cdb_valid && !rs.dispatch_src2_rdy && (rs.dispatch_src2_tag == rs.cdb_tag)) begin
            w_din.r2 = 1'b1;
            w_din.v2 = rs.cdb_data;
        end
    end

    // Shift down above the issued slot, then drop the new op into the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = w_wake[i];
            if (w_issue_fire && (i >= int'(w_sel))) begin
                w_next[i] = w_wake[i+1];
            end
            if (w_disp_fire && (CW'(i) == w_slot)) begin
                w_next[i] = w_din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (rs.flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_count <= w_cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_next[i];
            end
        end
    end

    always_comb begin
        rs.issue_valid    = w_found;
        rs.issue_aluop    = alu_add;
        rs.issue_a        = '0;
        rs.issue_b        = '0;
        rs.issue_dest_tag = '0;
        if (w_found) begin
            rs.issue_aluop    = r_ent[w_sel].op;
            rs.issue_a        = r_ent[w_sel].v1;
            rs.issue_b        = r_ent[w_sel].v2;
            rs.issue_dest_tag = r_ent[w_sel].dest;
        end
    end

    assign rs.count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
//  Module : tb_alu_rs
//  Brief  : Directed self-checking bench for the ALU reservation station.
//  Rev    : 1.0  initial release
// ============================================================================

module tb_alu_rs;
    import rv32i_types::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_chk;

    alu_rs_if #(.DEPTH(4), .TAG_W(3)) bus ();

    alu_rs #(.DEPTH(4), .TAG_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input alu_ops op,
                        input logic [31:0] a, input logic [2:0] ta, input logic ra,
                        input logic [31:0] b, input logic [2:0] tb2, input logic rb,
                        input logic [2:0] d);
        bus.dispatch_valid    = 1'b1;
        bus.dispatch_aluop    = op;
        bus.dispatch_src1_val = a;
        bus.dispatch_src1_tag = ta;
        bus.dispatch_src1_rdy = ra;
        bus.dispatch_src2_val = b;
        bus.dispatch_src2_tag = tb2;
        bus.dispatch_src2_rdy = rb;
        bus.dispatch_dest_tag = d;
    endtask

    task automatic cdb(input logic v, input logic [2:0] t, input logic [31:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = t;
        bus.cdb_data  = data;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        rst_n  = 1'b0;
        bus.flush = 1'b0;
        bus.issue_ready = 1'b0;
        disp(alu_add, 0, 0, 1'b0, 0, 0, 1'b0, 0);
        bus.dispatch_valid = 1'b0;
        cdb(1'b0, 0, 0);
        #12;
        check("rst_count", 32'(bus.count), 0);
        check("rst_issue_valid", 32'(bus.issue_valid), 0);
        check("rst_issue_a", bus.issue_a, 0);
        check("rst_disp_ready", 32'(bus.dispatch_ready), 1);
        rst_n = 1'b1;
        tick();

        // Simple ready add
        bus.issue_ready = 1'b1;
        disp(alu_add, 5, 0, 1'b1, 7, 0, 1'b1, 1);
        tick();
        bus.dispatch_valid = 1'b0;
        check("t1_count", 32'(bus.count), 1);
        check("t1_valid", 32'(bus.issue_valid), 1);
        check("t1_a", bus.issue_a, 5);
        check("t1_b", bus.issue_b, 7);
        check("t1_op", 32'(bus.issue_aluop), 32'(alu_add));
        tick();
        check("t1_count_after", 32'(bus.count), 0);
        check("t1_valid_after", 32'(bus.issue_valid), 0);

        // Pending src1 woken by CDB two cycles later
        disp(alu_sub, 0, 3, 1'b0, 1, 0, 1'b1, 5);
        tick();
        bus.dispatch_valid = 1'b0;
        check("t2_count", 32'(bus.count), 1);
        check("t2_wait0", 32'(bus.issue_valid), 0);
        tick();
        check("t2_wait1", 32'(bus.issue_valid), 0);
        cdb(1'b1, 3, 10);
        tick();
        cdb(1'b0, 0, 0);
        check("t2_valid", 32'(bus.issue_valid), 1);
        check("t2_a", bus.issue_a, 10);
        check("t2_b", bus.issue_b, 1);
        check("t2_op", 32'(bus.issue_aluop), 32'(alu_sub));
        check("t2_dest", 32'(bus.issue_dest_tag), 5);
        tick();
        check("t2_count_after", 32'(bus.count), 0);

        // Dispatch-time CDB capture
        bus.issue_ready = 1'b0;
        disp(alu_xor, 3, 0, 1'b1, 0, 2, 1'b0, 6);
        cdb(1'b1, 2, 32'hFFFF_FFFF);
        tick();
        bus.dispatch_valid = 1'b0;
        cdb(1'b0, 0, 0);
        check("t3_valid", 32'(bus.issue_valid), 1);
        check("t3_a", bus.issue_a, 3);
        check("t3_b", bus.issue_b, 32'hFFFF_FFFF);
        tick();
        check("t3_hold_b", bus.issue_b, 32'hFFFF_FFFF);
        bus.issue_ready = 1'b1;
        tick();
        check("t3_count_after", 32'(bus.count), 0);

        // Fill to full with ALU stalled, drop a fifth dispatch, drain in order
        bus.issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(alu_or, 32'(k * 10), 0, 1'b1, 1, 0, 1'b1, 3'(k));
            tick();
            check("t4_fill_count", 32'(bus.count), 32'(k + 1));
        end
        check("t4_full_ready", 32'(bus.dispatch_ready), 0);
        disp(alu_and, 99, 0, 1'b1, 99, 0, 1'b1, 7);
        tick();
        bus.dispatch_valid = 1'b0;
        check("t4_drop_count", 32'(bus.count), 4);
        check("t4_hold_dest", 32'(bus.issue_dest_tag), 0);
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_order_dest", 32'(bus.issue_dest_tag), 32'(k));
            check("t4_order_a", bus.issue_a, 32'(k * 10));
            tick();
        end
        check("t4_empty", 32'(bus.count), 0);
        check("t4_empty_valid", 32'(bus.issue_valid), 0);

        // Out-of-order issue with compaction
        bus.issue_ready = 1'b0;
        disp(alu_sll, 0, 4, 1'b0, 2, 0, 1'b1, 1);
        tick();
        disp(alu_srl, 3, 0, 1'b1, 0, 5, 1'b0, 2);
        tick();
        disp(alu_sra, 8, 0, 1'b1, 9, 0, 1'b1, 3);
        tick();
        check("t5_count3", 32'(bus.count), 3);
        check("t5_sel_dest", 32'(bus.issue_dest_tag), 3);
        bus.issue_ready = 1'b1;
        disp(alu_add, 0, 6, 1'b0, 4, 0, 1'b1, 4);
        tick();
        bus.dispatch_valid = 1'b0;
        check("t5_disp_issue_count", 32'(bus.count), 3);
        check("t5_none_ready", 32'(bus.issue_valid), 0);
        cdb(1'b1, 5, 55);
        tick();
        check("t5_wake2_dest", 32'(bus.issue_dest_tag), 2);
        check("t5_wake2_b", bus.issue_b, 55);
        cdb(1'b1, 4, 44);
        tick();
        check("t5_count2", 32'(bus.count), 2);
        check("t5_wake1_dest", 32'(bus.issue_dest_tag), 1);
        check("t5_wake1_a", bus.issue_a, 44);
        cdb(1'b1, 6, 66);
        tick();
        cdb(1'b0, 0, 0);
        check("t5_count1", 32'(bus.count), 1);
        check("t5_wake4_dest", 32'(bus.issue_dest_tag), 4);
        check("t5_wake4_a", bus.issue_a, 66);
        tick();
        check("t5_count0", 32'(bus.count), 0);

        // Flush beats a simultaneous dispatch
        bus.issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(alu_add, 1, 0, 1'b1, 1, 0, 1'b1, 3'(k));
            tick();
        end
        check("t6_count3", 32'(bus.count), 3);
        disp(alu_add, 2, 0, 1'b1, 2, 0, 1'b1, 5);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.dispatch_valid = 1'b0;
        check("t6_flush_count", 32'(bus.count), 0);
        check("t6_flush_valid", 32'(bus.issue_valid), 0);
        tick();
        check("t6_flush_retain", 32'(bus.count), 0);

        // Asynchronous reset mid-operation
        for (int k = 0; k < 2; k++) begin
            disp(alu_add, 7, 0, 1'b1, 7, 0, 1'b1, 3'(k + 1));
            tick();
        end
        bus.dispatch_valid = 1'b0;
        check("t7_count2", 32'(bus.count), 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_count", 32'(bus.count), 0);
        check("t7_rst_valid", 32'(bus.issue_valid), 0);
        check("t7_rst_dest", 32'(bus.issue_dest_tag), 0);
        check("t7_rst_ready", 32'(bus.dispatch_ready), 1);
        #1;
        rst_n = 1'b1;
        tick();
        check("t7_post_count", 32'(bus.count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
